// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and helpers for the pipeline hazard scheduler
package hazard_pkg;
   localparam int REG_W = 5;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   // $0 is hard-wired zero, so a write to it never creates a dependency
   function automatic logic reg_match(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
      return (dst != '0) && (dst == src);
   endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - datapath <-> hazard scheduler signal bundle
interface pipeline_hazard_ctrl_if #(
   parameter int STALL_CNT_W = 16
);
   import hazard_pkg::*;

   logic [REG_W-1:0]       RsD;
   logic [REG_W-1:0]       RtD;
   logic [REG_W-1:0]       RsE;
   logic [REG_W-1:0]       RtE;
   logic [REG_W-1:0]       WriteRegE;
   logic [REG_W-1:0]       WriteRegM;
   logic [REG_W-1:0]       WriteRegW;
   logic                   RegWriteE;
   logic                   RegWriteM;
   logic                   RegWriteW;
   logic                   MemReadE;
   logic                   MemReadM;
   logic                   BranchD;
   logic                   PCSrcD;
   logic                   MulDivD;
   logic                   HiLoReadD;
   logic                   MulDivStartE;
   logic                   StallF;
   logic                   StallD;
   logic                   FlushD;
   logic                   FlushE;
   logic [1:0]             ForwardAE;
   logic [1:0]             ForwardBE;
   logic                   ForwardAD;
   logic                   ForwardBD;
   logic                   MulDivBusy;
   logic [STALL_CNT_W-1:0] StallCycles;

   modport master (
      output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
      output RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM,
      output BranchD, PCSrcD, MulDivD, HiLoReadD, MulDivStartE,
      input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
      input  ForwardAD, ForwardBD, MulDivBusy, StallCycles
   );

   modport slave (
      input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
      input  RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM,
      input  BranchD, PCSrcD, MulDivD, HiLoReadD, MulDivStartE,
      output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
      output ForwardAD, ForwardBD, MulDivBusy, StallCycles
   );
endinterface

// File: rtl/muldiv_busy_ctr.sv
// rtl/muldiv_busy_ctr.sv - MULT/DIV occupancy counter driving the busy flag
module muldiv_busy_ctr #(
   parameter int MULDIV_LAT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy
);
   localparam int CNT_W = $clog2(MULDIV_LAT + 1);
   localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(MULDIV_LAT);

   logic [CNT_W-1:0] mdcnt;

   // A start while busy cannot be issued by a stalled D stage; drop it if it appears
   always_ff @(posedge clk) begin
      if (reset) begin
         mdcnt <= '0;
      end else if (start && (mdcnt == '0)) begin
         mdcnt <= LOAD_V;
      end else if (mdcnt != '0) begin
         mdcnt <= mdcnt - CNT_W'(1);
      end
   end

   assign busy = (mdcnt != '0);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - forwarding, stall and flush control for the 5-stage pipeline
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MULDIV_LAT  = 4,
   parameter int STALL_CNT_W = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   pipeline_hazard_ctrl_if.slave hz
);
   logic lwstall;
   logic brstall;
   logic mdstall;
   logic stall;
   logic md_busy;
   logic [STALL_CNT_W-1:0] stall_cycles;

   muldiv_busy_ctr #(.MULDIV_LAT(MULDIV_LAT)) u_muldiv_busy_ctr (
      .clk   (Clk),
      .reset (Reset),
      .start (hz.MulDivStartE),
      .busy  (md_busy)
   );

   always_comb begin
      hz.ForwardAE = FWD_RF;
      if (hz.RegWriteM && reg_match(hz.WriteRegM, hz.RsE))
         hz.ForwardAE = FWD_M;
      else if (hz.RegWriteW && reg_match(hz.WriteRegW, hz.RsE))
         hz.ForwardAE = FWD_W;

      hz.ForwardBE = FWD_RF;
      if (hz.RegWriteM && reg_match(hz.WriteRegM, hz.RtE))
         hz.ForwardBE = FWD_M;
      else if (hz.RegWriteW && reg_match(hz.WriteRegW, hz.RtE))
         hz.ForwardBE = FWD_W;
   end

   // A load in M has no result yet, so the D-stage comparator cannot take it
   assign hz.ForwardAD = hz.RegWriteM && !hz.MemReadM && reg_match(hz.WriteRegM, hz.RsD);
   assign hz.ForwardBD = hz.RegWriteM && !hz.MemReadM && reg_match(hz.WriteRegM, hz.RtD);

   assign lwstall = hz.MemReadE &&
                    (reg_match(hz.WriteRegE, hz.RsD) || reg_match(hz.WriteRegE, hz.RtD));
   assign brstall = hz.BranchD &&
                    ((hz.RegWriteE && (reg_match(hz.WriteRegE, hz.RsD) ||
                                       reg_match(hz.WriteRegE, hz.RtD))) ||
                     (hz.MemReadM  && (reg_match(hz.WriteRegM, hz.RsD) ||
                                       reg_match(hz.WriteRegM, hz.RtD))));
   assign mdstall = md_busy && (hz.MulDivD || hz.HiLoReadD);

   // Reset forces a clean bubble regardless of what the datapath presents
   assign stall = (lwstall || brstall || mdstall) && !Reset;

   assign hz.StallF     = stall;
   assign hz.StallD     = stall;
   assign hz.FlushE     = stall || Reset;
   assign hz.FlushD     = (hz.PCSrcD && !stall) || Reset;
   assign hz.MulDivBusy = md_busy;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      end
   end

   assign hz.StallCycles = stall_cycles;
endmodule
